// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: front-end for fpu_top.
// Requests are buffered in a DEPTH-entry command FIFO and issued to the FPU
// one at a time over the cmd/din1/din2/dval handshake. Each result comes back
// as a tagged response. Illegal opcodes are answered with err=1 and are never
// issued.
// Optional feature macro: FPU_TIMEOUT_EN. When it is defined, WAIT is aborted
// after TIMEOUT cycles without fpu_rdy.
module fpu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_cmd,
    input  logic [63:0]      req_din1,
    input  logic [63:0]      req_din2,
    input  logic [TAG_W-1:0] req_tag,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    // fpu_top side
    output logic [3:0]       fpu_cmd,
    output logic [63:0]      fpu_din1,
    output logic [63:0]      fpu_din2,
    output logic             fpu_dval,
    input  logic [63:0]      fpu_result,
    input  logic             fpu_rdy,
    output logic             busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    typedef struct packed {
        logic [3:0]       cmd;
        logic [63:0]      din1;
        logic [63:0]      din2;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    state_e           state_q, state_d;
    entry_t           fifo_mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             full, empty, push, pop;
    logic             ready_en_q;
    logic             tmo_hit;

    logic [3:0]       cmd_q;
    logic [63:0]      din1_q, din2_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic             err_q;

    assign wr_entry = '{cmd: req_cmd, din1: req_din1, din2: req_din2, tag: req_tag};
    assign head     = fifo_mem_q[rd_ptr_q[AW-1:0]];

    // Equal index bits with different wrap bits means the write pointer lapped the read pointer.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = req_valid && req_ready;
    // The head stays in the FIFO until its response is taken, so it counts toward full.
    assign pop   = (state_q == S_RESP) && rsp_ready;

`ifdef FPU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt_q;

    // Counts WAIT cycles; restarts from zero on every issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Asserted during the TIMEOUT-th WAIT cycle.
    assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    // Opens the request port on the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
            ready_en_q <= 1'b1;
        end
    end

    // FIFO read/write pointers; they wrap modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // FIFO storage.
    // NOTE: storage has no reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = is_legal(head.cmd) ? S_ISSUE : S_RESP;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (fpu_rdy || tmo_hit) state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand, tag and response capture; everything stays stable until the next dispatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q    <= '0;
            din1_q   <= '0;
            din2_q   <= '0;
            result_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        tag_q <= head.tag;
                        if (is_legal(head.cmd)) begin
                            cmd_q  <= head.cmd;
                            din1_q <= head.din1;
                            din2_q <= head.din2;
                        end else begin
                            result_q <= '0;
                            err_q    <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (fpu_rdy) begin
                        result_q <= fpu_result;
                        err_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM-decoded outputs.
    always_comb begin
        req_ready = ready_en_q && !full;
        fpu_dval  = (state_q == S_ISSUE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE) || !empty;
    end

    assign fpu_cmd    = cmd_q;
    assign fpu_din1   = din1_q;
    assign fpu_din2   = din2_q;
    assign rsp_result = result_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Directed bench for fpu_cmd_sequencer with a behavioural fpu_top stand-in
// and an in-order response scoreboard.
module tb_fpu_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 255;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid, req_ready;
    logic [3:0]       req_cmd;
    logic [63:0]      req_din1, req_din2;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid, rsp_ready;
    logic [63:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [3:0]       fpu_cmd;
    logic [63:0]      fpu_din1, fpu_din2, fpu_result;
    logic             fpu_dval, fpu_rdy, busy;

    logic             model_rdy, stray_rdy, fpu_mute;
    int               n_chk = 0;
    int               n_bad = 0;
    int               dval_cnt = 0;
    int               dval_ref;
    exp_t             exp_q[$];

    assign fpu_rdy = model_rdy | stray_rdy;

    fpu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_din1(req_din1), .req_din2(req_din2), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
        .fpu_dval(fpu_dval), .fpu_result(fpu_result), .fpu_rdy(fpu_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Known IEEE-754 single-precision vectors; anything else gets an
    // operand-order-sensitive mix so swapped or stale operands show up.
    function automatic logic [63:0] fpu_calc(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        if (c == 4'h1 && a == 64'h3FC00000 && b == 64'h40100000) return 64'h40700000;
        if (c == 4'h2 && a == 64'h40000000 && b == 64'h40400000) return 64'h40C00000;
        if (c == 4'h3 && a == 64'h40C00000 && b == 64'h40000000) return 64'h40400000;
        return a ^ {b[31:0], b[63:32]} ^ {60'd0, c};
    endfunction

    // fpu_top stand-in: answers each dval after 1..3 cycles unless muted.
    initial begin
        model_rdy  = 1'b0;
        fpu_result = 64'hDEAD_BEEF_DEAD_BEEF;
        forever begin
            @(posedge clk); #1;
            if (fpu_dval) begin
                dval_cnt++;
                if (!fpu_mute) begin
                    logic [63:0] res;
                    int lat;
                    res = fpu_calc(fpu_cmd, fpu_din1, fpu_din2);
                    lat = (fpu_cmd == 4'h2) ? 3 : 1;
                    repeat (lat) @(posedge clk);
                    #1;
                    fpu_result = res;
                    model_rdy  = 1'b1;
                    @(posedge clk); #1;
                    model_rdy  = 1'b0;
                    fpu_result = 64'hDEAD_BEEF_DEAD_BEEF;
                end
            end
        end
    end

    // Response monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_result", rsp_result, e.res);
                check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input logic [63:0] er, input logic ee);
        int n;
        exp_t e;
        req_valid = 1'b1;
        req_cmd   = c;
        req_din1  = a;
        req_din2  = b;
        req_tag   = t;
        n = 0;
        while (!req_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_ready", 64'(req_ready), 64'd1);
        if (req_ready) begin
            e.res = er;
            e.tag = t;
            e.err = ee;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fpu_mute  = 1'b0;
        stray_rdy = 1'b0;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_din1  = '0;
        req_din2  = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_fpu_dval", 64'(fpu_dval), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_rsp_result", rsp_result, 64'd0);
            req_valid = 1'($urandom);
            req_cmd   = 4'($urandom);
            req_din1  = {$urandom, $urandom};
            rsp_ready = 1'($urandom);
            stray_rdy = 1'($urandom);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        stray_rdy = 1'b0;
        rst_n     = 1'b1;
        check("rel_req_ready_0", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check("rel_req_ready_1", 64'(req_ready), 64'd1);

        // fpu_rdy while idle must be ignored.
        stray_rdy = 1'b1;
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        @(posedge clk); #1;
        check("idle_rdy_rsp_valid", 64'(rsp_valid), 64'd0);
        check("idle_rdy_busy", 64'(busy), 64'd0);

        // SP ADD with dispatch latency and single dval pulse.
        dval_ref = dval_cnt;
        send(4'h1, 64'h3FC00000, 64'h40100000, 4'd3, 64'h40700000, 1'b0);
        check("add_dval_n", 64'(fpu_dval), 64'd0);
        @(posedge clk); #1;
        check("add_dval_n1", 64'(fpu_dval), 64'd1);
        check("add_fpu_cmd", 64'(fpu_cmd), 64'h1);
        check("add_fpu_din1", fpu_din1, 64'h3FC00000);
        check("add_fpu_din2", fpu_din2, 64'h40100000);
        @(posedge clk); #1;
        check("add_dval_n2", 64'(fpu_dval), 64'd0);
        wait_idle("add");
        check("add_dval_pulses", 64'(dval_cnt - dval_ref), 64'd1);

        // MUL then DIV back-to-back.
        send(4'h2, 64'h40000000, 64'h40400000, 4'd1, 64'h40C00000, 1'b0);
        send(4'h3, 64'h40C00000, 64'h40000000, 4'd2, 64'h40400000, 1'b0);
        wait_idle("muldiv");

        // Illegal opcodes, then a legal one.
        dval_ref = dval_cnt;
        send(4'h4, 64'h1234, 64'h5678, 4'd8, 64'd0, 1'b1);
        send(4'hF, 64'h9ABC, 64'hDEF0, 4'd9, 64'd0, 1'b1);
        wait_idle("illegal");
        check("illegal_no_dval", 64'(dval_cnt - dval_ref), 64'd0);
        send(4'h5, 64'h0000_0001_4000_0000, 64'h3F80_0000, 4'd10,
             fpu_calc(4'h5, 64'h0000_0001_4000_0000, 64'h3F80_0000), 1'b0);
        wait_idle("after_illegal");

        // Fill the FIFO with the consumer stalled.
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [3:0]  c;
            logic [63:0] a;
            logic [63:0] b;
            c = 4'(5 + (i % 3));
            a = 64'h1111_0000_0000_0000 + 64'(i);
            b = 64'h0000_0000_2222_0000 + 64'(i * 16);
            send(c, a, b, 4'(4 + i), fpu_calc(c, a, b), 1'b0);
        end
        check("full_req_ready", 64'(req_ready), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("full_hold_req_ready", 64'(req_ready), 64'd0);
        check("full_hold_rsp_valid", 64'(rsp_valid), 64'd1);
        check("full_hold_busy", 64'(busy), 64'd1);
        rsp_ready = 1'b1;
        send(4'h6, 64'hABCD, 64'h0001_0000_0000_0000, 4'd15,
             fpu_calc(4'h6, 64'hABCD, 64'h0001_0000_0000_0000), 1'b0);
        wait_idle("full_drain");

`ifdef FPU_TIMEOUT_EN
        // FPU never answers: abort after TIMEOUT cycles, late rdy ignored.
        fpu_mute = 1'b1;
        send(4'h7, 64'h77, 64'h88, 4'd11, 64'd0, 1'b1);
        wait_idle("timeout");
        fpu_mute  = 1'b0;
        stray_rdy = 1'b1;
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("late_rdy_rsp_valid", 64'(rsp_valid), 64'd0);
        check("late_rdy_busy", 64'(busy), 64'd0);
`endif

        // Reset in the middle of an operation discards it without a response.
        fpu_mute = 1'b1;
        send(4'h2, 64'h5, 64'h6, 4'd12, 64'd0, 1'b0);
        send(4'h1, 64'h7, 64'h8, 4'd13, 64'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_req_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n    = 1'b1;
        fpu_mute = 1'b0;
        @(posedge clk); #1;
        check("midrst_after_busy", 64'(busy), 64'd0);
        check("midrst_after_ready", 64'(req_ready), 64'd1);
        send(4'h3, 64'h40C00000, 64'h40000000, 4'd14, 64'h40400000, 1'b0);
        wait_idle("recover");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
